// File: rtl/encode42_stream_if.sv
// rtl/encode42_stream_if.sv - input word stream and encoded result stream of encode42_stream
interface encode42_stream_if;
  logic [3:0] in;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_err, out_valid
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_err, out_valid
  );
endinterface

// File: rtl/encode42_stream.sv
// rtl/encode42_stream.sv - registered 4-to-2 one-hot encoder with 2-entry result FIFO
// Optional macro ENCODE42_PRIORITY_EN: multi-hot words encode their highest set bit.
module encode42_stream #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  encode42_stream_if.slave stream,
  input  logic             clr_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t     state;
  state_t     state_next;
  logic [2:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       accept;
  logic       pop;
  logic [1:0] enc_out;
  logic       enc_err;

  assign accept = stream.in_valid && stream.in_ready;
  assign pop    = stream.out_valid && stream.out_ready;

  always_comb begin
    enc_out = 2'b00;
    enc_err = 1'b0;
`ifdef ENCODE42_PRIORITY_EN
    if (stream.in[3])       enc_out = 2'b11;
    else if (stream.in[2])  enc_out = 2'b10;
    else if (stream.in[1])  enc_out = 2'b01;
    else if (!stream.in[0]) enc_err = 1'b1;
`else
    case (stream.in)
      4'b0001: enc_out = 2'b00;
      4'b0010: enc_out = 2'b01;
      4'b0100: enc_out = 2'b10;
      4'b1000: enc_out = 2'b11;
      default: enc_err = 1'b1;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Accept is impossible in FULL, so only the pop edge leaves it.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !pop)      state_next = FULL;
        else if (pop && !accept) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    stream.in_ready  = (state != FULL) && !rst;
    stream.out_valid = (state != EMPTY);
    stream.out       = 2'b00;
    stream.out_err   = 1'b0;
    if (stream.out_valid) {stream.out, stream.out_err} = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= 3'b000;
      mem[1] <= 3'b000;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {enc_out, enc_err};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_err)
      err_count <= '0;
    else if (accept && enc_err && err_count != ERR_MAX)
      err_count <= err_count + ERR_W'(1);
  end

endmodule
